// File: rtl/alu_hs_mc_if.sv
// -----------------------------------------------------------------------------
// alu_hs_mc_if
// Handshake/bus bundle between the operand-issue logic (master) and the
// multi-cycle ALU (slave).
//
// Signals:
//   in_valid / in_ready   : request handshake (operands + opcode)
//   A, B                  : WIDTH-bit operands
//   ALU_sel               : 4-bit opcode
//   out_valid / out_ready : result handshake
//   ALU_out               : WIDTH-bit result
//   Zero, Carry, Negative, Overflow, Illegal : result flags
//   busy                  : a multi-cycle operation is executing
// -----------------------------------------------------------------------------
interface alu_hs_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_out;
    logic             Zero;
    logic             Carry;
    logic             Negative;
    logic             Overflow;
    logic             Illegal;
    logic             busy;

    modport master (
        output in_valid, A, B, ALU_sel, out_ready,
        input  in_ready, out_valid, ALU_out, Zero, Carry, Negative, Overflow,
               Illegal, busy
    );

    modport slave (
        input  in_valid, A, B, ALU_sel, out_ready,
        output in_ready, out_valid, ALU_out, Zero, Carry, Negative, Overflow,
               Illegal, busy
    );
endinterface

// File: rtl/alu_hs_mc.sv
// -----------------------------------------------------------------------------
// alu_hs_mc
// Handshaked ALU with one operation in flight. Single-cycle ops (add/sub,
// logic, shifts, compares) produce a result one cycle after accept; MUL/MULHU
// run an iterative shift-add multiplier for WIDTH cycles.
//
// Optional feature: define ALU_DIV_EN to add DIVU/REMU via a restoring
// divider (one quotient bit per cycle). Without it, 1100/1101 are illegal.
//
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-low
//   bus   : alu_hs_mc_if.slave (handshakes, operands, result, flags, busy)
// -----------------------------------------------------------------------------
module alu_hs_mc #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alu_hs_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_b;      // multiplicand / divisor
    logic [WIDTH-1:0] r_hi;     // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;     // multiplier -> product low half / dividend -> quotient
    logic [SHW-1:0]   r_cnt;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_carry;
    logic             r_neg;
    logic             r_ovf;
    logic             r_ill;

    logic             w_in_ready;
    logic             w_accept;

    // DONE only frees the slot when the consumer takes the result this edge.
    assign w_in_ready = reset & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready));
    assign w_accept   = bus.in_valid & w_in_ready;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live bus at the accept edge
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_ill;
    logic             w_multi;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        w_sum   = {1'b0, bus.A} + {1'b0, bus.B};
        w_diff  = {1'b0, bus.A} - {1'b0, bus.B};
        w_shamt = bus.B[SHW-1:0];
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_ill   = 1'b0;
        w_multi = 1'b0;
        case (bus.ALU_sel)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];   // borrow out == A < B unsigned
                w_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  w_res = bus.A & bus.B;
            OP_OR:   w_res = bus.A | bus.B;
            OP_XOR:  w_res = bus.A ^ bus.B;
            OP_SLL:  w_res = bus.A << w_shamt;
            OP_SRL:  w_res = bus.A >> w_shamt;
            OP_SRA:  w_res = $signed(bus.A) >>> w_shamt;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_MUL, OP_MULHU: w_multi = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIVU, OP_REMU: w_multi = 1'b1;
`endif
            default: w_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of the multi-cycle engine
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   w_rsh;
    logic [WIDTH:0]   w_trial;
`endif

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier LSB is
        // set, then shift {carry, hi, lo} right; lo fills with product bits.
        w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_nhi  = w_madd[WIDTH:1];
        w_nlo  = {w_madd[0], r_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        // Restoring step: bring down the next dividend bit, keep the trial
        // subtraction only if it did not go negative. A zero divisor always
        // succeeds, giving an all-ones quotient and remainder == A.
        w_rsh   = {r_hi, r_lo[WIDTH-1]};
        w_trial = w_rsh - {1'b0, r_b};
        if ((r_op == OP_DIVU) || (r_op == OP_REMU)) begin
            if (w_trial[WIDTH]) begin
                w_nhi = w_rsh[WIDTH-1:0];
                w_nlo = {r_lo[WIDTH-2:0], 1'b0};
            end else begin
                w_nhi = w_trial[WIDTH-1:0];
                w_nlo = {r_lo[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    // Result of the final iteration, selected by the latched opcode.
    logic [WIDTH-1:0] w_fres;
    logic             w_fv;

    always_comb begin
        w_fres = w_nlo;
        w_fv   = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_fres = w_nlo;
                w_fv   = |w_nhi;
            end
            OP_MULHU: w_fres = w_nhi;
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                w_fres = w_nlo;
                w_fv   = (r_b == '0);
            end
            OP_REMU: begin
                w_fres = w_nhi;
                w_fv   = (r_b == '0);
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_b         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_ill       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_state     <= S_EXEC;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_op        <= bus.ALU_sel;
                            r_b         <= bus.B;
                            r_hi        <= '0;
                            r_lo        <= bus.A;
                            r_cnt       <= '0;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out       <= w_res;
                            r_zero      <= (w_res == '0);
                            r_carry     <= w_c;
                            r_neg       <= w_res[WIDTH-1];
                            r_ovf       <= w_v;
                            r_ill       <= w_ill;
                        end
                    end else if ((r_state == S_DONE) && bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_EXEC: begin
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out       <= w_fres;
                        r_zero      <= (w_fres == '0);
                        r_carry     <= 1'b0;
                        r_neg       <= w_fres[WIDTH-1];
                        r_ovf       <= w_fv;
                        r_ill       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ALU_out   = r_out;
    assign bus.Zero      = r_zero;
    assign bus.Carry     = r_carry;
    assign bus.Negative  = r_neg;
    assign bus.Overflow  = r_ovf;
    assign bus.Illegal   = r_ill;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_hs_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_hs_mc
// Self-checking bench for alu_hs_mc at WIDTH=8: directed scenarios plus
// randomized operations compared against an arithmetic reference model.
// Honours ALU_DIV_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_hs_mc;
    localparam int W = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_hs_mc_if #(.WIDTH(W)) bus ();

    alu_hs_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         ill;
        logic         multi;
        int           lat;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        int ua, ub, sa, sb, r, amt;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        amt = ub % W;
        r = 0;
        e = '0;
        e.lat = 1;
        case (op)
            4'd0: begin
                r = ua + ub;
                e.c = (r > 255);
                e.v = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            4'd1: begin
                r = ua - ub;
                e.c = (ua < ub);
                e.v = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ua << amt;
            4'd6: r = ua >> amt;
            4'd7: r = sa >>> amt;
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (ua < ub) ? 1 : 0;
            4'd10: begin
                r = ua * ub;
                e.v = (r > 255);
                e.multi = 1'b1;
                e.lat = W + 1;
            end
            4'd11: begin
                r = (ua * ub) / 256;
                e.multi = 1'b1;
                e.lat = W + 1;
            end
`ifdef ALU_DIV_EN
            4'd12, 4'd13: begin
                e.multi = 1'b1;
                e.lat = W + 1;
                if (ub == 0) begin
                    r = (op == 4'd12) ? 255 : ua;
                    e.v = 1'b1;
                end else begin
                    r = (op == 4'd12) ? ua / ub : ua % ub;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.res = W'(r);
        return e;
    endfunction

    task automatic check_result(input string name, input exp_t e);
        check({name, ".out"}, bus.ALU_out,  e.res);
        check({name, ".Z"},   bus.Zero,     e.res == '0);
        check({name, ".C"},   bus.Carry,    e.c);
        check({name, ".N"},   bus.Negative, e.res[W-1]);
        check({name, ".V"},   bus.Overflow, e.v);
        check({name, ".ILL"}, bus.Illegal,  e.ill);
    endtask

    // Issue one op from IDLE, measure latency, check the result, optionally
    // stall the consumer for `hold` cycles, then consume.
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        exp_t e;
        int   lat;
        e = model(op, a, b);
        bus.A         = a;
        bus.B         = b;
        bus.ALU_sel   = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        #1;
        check({name, ".in_ready"}, bus.in_ready, 1'b1);
        next_cycle();
        bus.in_valid = 1'b0;
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
        bus.ALU_sel  = 4'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            check({name, ".busy"},      bus.busy, 1'b1);
            check({name, ".ready_exe"}, bus.in_ready, 1'b0);
            next_cycle();
            lat++;
        end
        check({name, ".latency"}, lat, e.lat);
        check({name, ".busy_done"}, bus.busy, 1'b0);
        check_result(name, e);
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            check({name, ".hold_ov"},  bus.out_valid, 1'b1);
            check({name, ".hold_out"}, bus.ALU_out, e.res);
            check({name, ".hold_rdy"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        next_cycle();
        check({name, ".consumed"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic [3:0] op;
        logic [W-1:0] a, b;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALU_sel   = '0;
        repeat (3) next_cycle();

        // Reset state
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.in_ready",  bus.in_ready,  1'b0);
        check("rst.busy",      bus.busy,      1'b0);
        check("rst.out",       bus.ALU_out,   '0);
        check("rst.flags", {bus.Zero, bus.Carry, bus.Negative, bus.Overflow, bus.Illegal}, 5'b0);
        reset = 1'b1;
        next_cycle();

        // Directed arithmetic / compare set
        run_op("add_125_3",  OP_ADD,  8'd125, 8'd3,  0);
        run_op("mul_20_13",  OP_MUL,  8'd20,  8'd13, 0);
        run_op("mulhu_20_13", OP_MULHU, 8'd20, 8'd13, 0);
        run_op("sra",        OP_SRA,  8'h90,  8'h0A, 0);
        run_op("slt",        OP_SLT,  8'hFD,  8'h02, 0);
        run_op("sltu",       OP_SLTU, 8'hFD,  8'h02, 0);
        run_op("illegal",    4'b1111, 8'h5A,  8'hA5, 0);
        run_op("divu_200_7", OP_DIVU, 8'd200, 8'd7,  0);
        run_op("remu_200_7", OP_REMU, 8'd200, 8'd7,  0);
        run_op("divu_9_0",   OP_DIVU, 8'd9,   8'd0,  0);
        run_op("remu_9_0",   OP_REMU, 8'd9,   8'd0,  2);

        // Back-to-back: SUB then AND accepted while SUB result is consumed
        bus.A = 8'd5; bus.B = 8'd13; bus.ALU_sel = OP_SUB;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        next_cycle();
        check_result("b2b_sub", model(OP_SUB, 8'd5, 8'd13));
        check("b2b_sub.ov", bus.out_valid, 1'b1);
        bus.A = 8'd12; bus.B = 8'd10; bus.ALU_sel = OP_AND;
        #1;
        check("b2b.in_ready", bus.in_ready, 1'b1);
        next_cycle();
        bus.in_valid = 1'b0;
        check("b2b_and.ov", bus.out_valid, 1'b1);
        check_result("b2b_and", model(OP_AND, 8'd12, 8'd10));
        next_cycle();
        check("b2b.idle", bus.out_valid, 1'b0);

        // Back-pressure: XOR result held 5 cycles with a pending ADD waiting
        bus.A = 8'd12; bus.B = 8'd10; bus.ALU_sel = OP_XOR;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        next_cycle();
        bus.A = 8'd100; bus.B = 8'd27; bus.ALU_sel = OP_ADD;
        #1;
        check("bp.ov", bus.out_valid, 1'b1);
        check_result("bp_xor", model(OP_XOR, 8'd12, 8'd10));
        for (int i = 0; i < 5; i++) begin
            check("bp.in_ready", bus.in_ready, 1'b0);
            next_cycle();
            check("bp.hold_out", bus.ALU_out, 8'd6);
            check("bp.hold_ov",  bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release_rdy", bus.in_ready, 1'b1);
        next_cycle();
        bus.in_valid = 1'b0;
        check("bp_add.ov", bus.out_valid, 1'b1);
        check_result("bp_add", model(OP_ADD, 8'd100, 8'd27));
        next_cycle();
        check("bp.idle", bus.out_valid, 1'b0);

        // Reset during the 4th EXEC cycle of a MUL
        bus.A = 8'd20; bus.B = 8'd13; bus.ALU_sel = OP_MUL; bus.in_valid = 1'b1;
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (3) next_cycle();
        check("mrst.busy_before", bus.busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mrst.in_ready", bus.in_ready, 1'b0);
        next_cycle();
        check("mrst.out_valid", bus.out_valid, 1'b0);
        check("mrst.busy",      bus.busy, 1'b0);
        check("mrst.out",       bus.ALU_out, '0);
        check("mrst.flags", {bus.Zero, bus.Carry, bus.Negative, bus.Overflow, bus.Illegal}, 5'b0);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            check("mrst.no_result", bus.out_valid, 1'b0);
        end
        run_op("add_5_3", OP_ADD, 8'd5, 8'd3, 0);

        // Randomized operations with corner-biased operands and random stalls
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3) * 85) : W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3) * 85) : W'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            run_op($sformatf("rnd%0d_op%0h", n, op), op, a, b, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_hs_mc.md
Name: alu_hs_mc

Overview:
- Parametrised successor to the team's single-op sequential ALU.
- Adds valid/ready handshakes on input and output, result hold under back-pressure, and unsigned/signed compare variants.
- Adds an iterative multi-cycle multiplier, with an optional restoring divider.
- Sits between the operand-issue logic and the writeback stage of the datapath; one operation in flight at a time.

Parameters:
- WIDTH, 8: operand/result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH): shift-amount bits taken from B (derived; do not override).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-low (0 = reset); sampled on rising clk.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept; forced 0 while reset=0.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_sel  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- ALU_out  out  WIDTH  result.
- Zero  out  1  flag: ALU_out == 0.
- Carry  out  1  flag: carry/borrow, per opcode.
- Negative  out  1  flag: ALU_out[WIDTH-1].
- Overflow  out  1  flag: overflow/truncation, per opcode.
- Illegal  out  1  flag: unsupported opcode.
- busy  out  1  multi-cycle operation executing.

Behaviour:
- Reset:
  - state IDLE; out_valid, ALU_out, all flags, busy = 0; in_ready = 0 during reset.
  - A reset asserted mid-operation abandons the operation. No result is produced, and the next accept after reset works normally.
- Accept: transfer occurs when in_valid & in_ready at a rising edge. A, B and ALU_sel are registered then; later input changes are ignored.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: accepting a single-cycle op goes to DONE; accepting a multi-cycle op goes to EXEC.
  - EXEC: counter runs WIDTH cycles, then DONE.
  - DONE: out_valid=1. out_ready=1 with no new accept goes to IDLE. out_ready=1 with a simultaneous accept goes to DONE or EXEC per the new op.
- in_ready = reset & ((state==IDLE) | (state==DONE & out_ready)). This gives a throughput of 1 op/cycle for single-cycle ops.
- Latency, accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL, MULHU: WIDTH+1 cycles; busy=1 for the WIDTH EXEC cycles.
- Back-pressure: in DONE with out_ready=0, ALU_out and all flags hold stable and in_ready=0.
- Opcodes (unlisted flags are 0):
  - 0000 ADD: A+B mod 2^WIDTH. Carry = carry-out; Overflow = signed overflow.
  - 0001 SUB: A-B. Carry = borrow (A<B unsigned); Overflow = signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA: shift A by B[SHW-1:0]; upper bits of B are ignored.
  - 1000 SLT: result 1 if A<B signed, else 0. 1001 SLTU: same comparison, unsigned.
  - 1010 MUL: low WIDTH bits of the unsigned product, by iterative shift-add (one partial product per cycle). Overflow = 1 if the high half is nonzero.
  - 1011 MULHU: high WIDTH bits of the unsigned product.
  - 1100 DIVU / 1101 REMU: see Optional Feature.
  - Others: Illegal=1, ALU_out=0, Zero=1, other flags 0; single-cycle.
- Zero and Negative are always derived from the final ALU_out, for every opcode.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined:
  - 1100 DIVU gives the unsigned quotient; 1101 REMU gives the unsigned remainder.
  - Implemented as a restoring divider, one bit per cycle: WIDTH EXEC cycles, WIDTH+1 latency, busy=1 while executing.
  - Divide-by-zero: quotient all-ones, remainder = A, Overflow=1; same latency.
- Undefined: 1100 and 1101 are treated as illegal opcodes. No divider logic is present.

Test Plan (WIDTH=8):
- ADD A=125, B=3 -> out_valid exactly 1 cycle after accept; ALU_out=128, Z=0, C=0, N=1, V=1.
- SUB A=5, B=13 -> ALU_out=248, C=1, N=1, V=0. Back-to-back with AND 12,10 (out_ready=1) -> accepted the same cycle the SUB result is consumed; next-cycle ALU_out=8.
- MUL A=20, B=13 -> ALU_out=4, V=1 after exactly 9 cycles. busy=1 and in_ready=0 during EXEC. MULHU on the same operands gives ALU_out=1.
- Shift/compare set:
  - SRA 0x90 by B=0x0A (amount 2) -> 0xE4, N=1.
  - SLT A=0xFD, B=2 -> 1.
  - SLTU A=0xFD, B=2 -> 0, Z=1.
  - ALU_sel=1111 -> Illegal=1, ALU_out=0.
- Back-pressure: out_ready=0 for 5 cycles after an XOR 12,10 result -> ALU_out stays 6, in_ready=0, and a pending ADD is not accepted. Raise out_ready -> ADD accepted on that edge.
- reset=0 at the 4th EXEC cycle of MUL -> next edge: out_valid=0, busy=0, all outputs 0. After release, ADD 5,3 -> 8, correct.
- With ALU_DIV_EN defined:
  - DIVU 200/7 -> 28 after 9 cycles.
  - REMU 200/7 -> 4.
  - DIVU 9/0 -> 255, V=1.
